// File: rtl/threshold_loader_pkg.sv
// -----------------------------------------------------------------------------
// threshold_loader_pkg
//
// Purpose: shared definitions for the Tanimoto threshold RAM loader.
//   - FSM state encoding (IDLE, DIV, WRITE, DONE)
//   - default parameter values
//   - running-product width derivation
//   - saturation value for a table entry
// -----------------------------------------------------------------------------
package threshold_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        WRITE,
        DONE
    } state_t;

    localparam int DEF_VECTOR_WIDTH = 920;
    localparam int DEF_CNT_WIDTH    = $clog2(DEF_VECTOR_WIDTH);
    localparam int DEF_THR_WIDTH    = 8;

    // c * (N + D) needs CNT_WIDTH bits for c plus THR_WIDTH+1 bits for N+D.
    function automatic int prod_width(input int cnt_w, input int thr_w);
        return cnt_w + thr_w + 1;
    endfunction

    // Largest value an entry of CNT_WIDTH+1 bits can hold.
    function automatic int sat_value(input int cnt_w);
        return (1 << (cnt_w + 1)) - 1;
    endfunction

    localparam int DEF_PROD_WIDTH = prod_width(DEF_CNT_WIDTH, DEF_THR_WIDTH);

endpackage

// File: rtl/thr_serial_divider.sv
// -----------------------------------------------------------------------------
// thr_serial_divider
//
// Purpose: restoring divider, one quotient bit per clock, MSB first.
//   The operands are captured on start.
//   done is high during the PROD_WIDTH-th cycle after the start edge.
//   In that cycle, quotient carries the complete result, so the caller can
//   register it on the same edge that ends the division.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   start    in   capture dividend/divisor and begin a division
//   dividend in   PROD_WIDTH-bit dividend
//   divisor  in   THR_WIDTH-bit divisor (zero gives an all-ones quotient)
//   done     out  final-iteration flag, one cycle
//   quotient out  quotient including the bit resolved this cycle
// -----------------------------------------------------------------------------
module thr_serial_divider
    import threshold_loader_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int THR_WIDTH  = DEF_THR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PROD_WIDTH-1:0] dividend,
    input  logic [THR_WIDTH-1:0]  divisor,
    output logic                  done,
    output logic [PROD_WIDTH-1:0] quotient
);

    localparam int CW = $clog2(PROD_WIDTH);

    logic                  running;
    logic [CW-1:0]         count;
    logic [THR_WIDTH-1:0]  rem;
    logic [THR_WIDTH-1:0]  div_r;
    // Dividend bits shift out at the top while quotient bits shift in at the bottom.
    logic [PROD_WIDTH-1:0] dq;

    logic [THR_WIDTH:0]    shifted;
    logic [THR_WIDTH:0]    diff;
    logic                  ge;
    logic [THR_WIDTH-1:0]  rem_next;

    always_comb begin
        shifted  = {rem, dq[PROD_WIDTH-1]};
        ge       = (shifted >= {1'b0, div_r});
        diff     = shifted - {1'b0, div_r};
        // When the trial subtraction fails, shifted < divisor, so its top bit is zero.
        rem_next = ge ? diff[THR_WIDTH-1:0] : shifted[THR_WIDTH-1:0];
    end

    assign quotient = {dq[PROD_WIDTH-2:0], ge};
    assign done     = running && (count == CW'(PROD_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            count   <= '0;
            rem     <= '0;
            div_r   <= '0;
            dq      <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            rem     <= '0;
            div_r   <= divisor;
            dq      <= dividend;
        end else if (running) begin
            rem   <= rem_next;
            dq    <= quotient;
            count <= count + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/threshold_loader.sv
// -----------------------------------------------------------------------------
// threshold_loader
//
// Purpose: fills the comparator's Tanimoto threshold RAM.
//   For every c in 0..VECTOR_WIDTH, it writes floor(c*(N+D)/N) at address c.
//   The value saturates to the entry width; N == 0 writes all-ones.
//   The product c*(N+D) is accumulated by addition, with no multiplier.
//   Each entry takes PROD_WIDTH divide cycles plus one write cycle.
//
// Configuration macro: THRESHOLD_LOADER_CHECKSUM_EN
//   When defined, o_Checksum is a 16-bit wrap-around sum of the written entries.
//   When undefined, o_Checksum is tied to zero.
//
// Ports:
//   clk          in   clock, also the RAM write clock
//   rst          in   synchronous active-high reset
//   i_Start      in   load request, ignored while busy
//   i_ThrNum     in   threshold numerator N
//   i_ThrDen     in   threshold denominator D
//   o_Busy       out  load in progress (table contents invalid)
//   o_Done       out  one-cycle pulse after the last write
//   o_BRAM_Addr  out  write address c
//   o_BRAM_Din   out  entry value
//   o_BRAM_En    out  RAM enable, equal to o_BRAM_WrEn
//   o_BRAM_WrEn  out  write strobe, one cycle per entry
//   o_Checksum   out  running checksum of written entries
// -----------------------------------------------------------------------------
module threshold_loader
    import threshold_loader_pkg::*;
#(
    parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
    parameter int THR_WIDTH    = DEF_THR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_Start,
    input  logic [THR_WIDTH-1:0] i_ThrNum,
    input  logic [THR_WIDTH-1:0] i_ThrDen,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
    output logic [CNT_WIDTH:0]   o_BRAM_Din,
    output logic                 o_BRAM_En,
    output logic                 o_BRAM_WrEn,
    output logic [15:0]          o_Checksum
);

    localparam int PROD_WIDTH = prod_width(CNT_WIDTH, THR_WIDTH);
    localparam logic [CNT_WIDTH:0] ENTRY_MAX = (CNT_WIDTH + 1)'(sat_value(CNT_WIDTH));

    state_t                 state;
    logic [THR_WIDTH-1:0]   num_r;
    logic [THR_WIDTH:0]     k_r;
    logic [PROD_WIDTH-1:0]  prod_r;
    logic [CNT_WIDTH-1:0]   cnt_r;

    logic                   accept;
    logic                   last_entry;
    logic [PROD_WIDTH-1:0]  prod_next;
    logic                   div_start;
    logic [PROD_WIDTH-1:0]  div_dividend;
    logic [THR_WIDTH-1:0]   div_divisor;
    logic                   div_done;
    logic [PROD_WIDTH-1:0]  div_q;
    logic [CNT_WIDTH:0]     entry_val;

    // Start is honoured in IDLE and in the DONE cycle.
    // A new load may therefore begin in the cycle in which o_Done pulses.
    // Each division is launched on the edge that enters DIV.
    // The operand is the product for the entry about to be computed.
    // The first entry always divides zero by the incoming numerator.
    always_comb begin
        accept       = ((state == IDLE) || (state == DONE)) && i_Start;
        last_entry   = (cnt_r == CNT_WIDTH'(VECTOR_WIDTH));
        prod_next    = prod_r + PROD_WIDTH'(k_r);
        div_start    = accept || ((state == WRITE) && !last_entry);
        div_dividend = accept ? '0 : prod_next;
        div_divisor  = accept ? i_ThrNum : num_r;
    end

    // Saturate the quotient to the entry width.
    // A zero numerator bypasses the divider entirely.
    always_comb begin
        entry_val = div_q[CNT_WIDTH:0];
        if (num_r == '0) begin
            entry_val = ENTRY_MAX;
        end else if (|div_q[PROD_WIDTH-1:CNT_WIDTH+1]) begin
            entry_val = ENTRY_MAX;
        end
    end

    thr_serial_divider #(
        .PROD_WIDTH (PROD_WIDTH),
        .THR_WIDTH  (THR_WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .done     (div_done),
        .quotient (div_q)
    );

    // Load sequencer. The RAM strobes are high for exactly the WRITE cycle.
    // Addr and Din are updated on the same edge, so they are stable under the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            num_r       <= '0;
            k_r         <= '0;
            prod_r      <= '0;
            cnt_r       <= '0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_BRAM_Addr <= '0;
            o_BRAM_Din  <= '0;
            o_BRAM_En   <= 1'b0;
            o_BRAM_WrEn <= 1'b0;
        end else begin
            o_Done      <= 1'b0;
            o_BRAM_En   <= 1'b0;
            o_BRAM_WrEn <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        num_r  <= i_ThrNum;
                        k_r    <= {1'b0, i_ThrNum} + {1'b0, i_ThrDen};
                        prod_r <= '0;
                        cnt_r  <= '0;
                        o_Busy <= 1'b1;
                        state  <= DIV;
                    end else begin
                        state  <= IDLE;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        o_BRAM_Addr <= cnt_r;
                        o_BRAM_Din  <= entry_val;
                        o_BRAM_En   <= 1'b1;
                        o_BRAM_WrEn <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_entry) begin
                        o_Busy <= 1'b0;
                        o_Done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt_r  <= cnt_r + CNT_WIDTH'(1);
                        prod_r <= prod_next;
                        state  <= DIV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef THRESHOLD_LOADER_CHECKSUM_EN
    logic [15:0] checksum_r;

    // The sum picks up each entry on the edge that ends its write cycle.
    // It is therefore final by the time o_Done is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_r <= '0;
        end else if (accept) begin
            checksum_r <= '0;
        end else if (state == WRITE) begin
            checksum_r <= checksum_r + 16'(o_BRAM_Din);
        end
    end

    assign o_Checksum = checksum_r;
`else
    assign o_Checksum = '0;
`endif

endmodule

// File: tb/tb_threshold_loader.sv
// -----------------------------------------------------------------------------
// tb_threshold_loader
//
// Self-checking bench for threshold_loader.
// An arithmetic reference model predicts each table entry from N and D.
// Write strobes are timed relative to the first cycle in which o_Busy is seen high.
// Threshold inputs are scrambled randomly during every load.
// Stray start pulses are injected mid-load.
// -----------------------------------------------------------------------------
module tb_threshold_loader;

    localparam int VW        = 920;
    localparam int ENTRIES   = VW + 1;
    localparam int PER_ENTRY = 20;
    localparam int LOAD_LEN  = ENTRIES * PER_ENTRY;
    localparam int SAT       = 2047;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_Start = 1'b0;
    logic [7:0]  i_ThrNum = '0;
    logic [7:0]  i_ThrDen = '0;
    logic        o_Busy;
    logic        o_Done;
    logic [9:0]  o_BRAM_Addr;
    logic [10:0] o_BRAM_Din;
    logic        o_BRAM_En;
    logic        o_BRAM_WrEn;
    logic [15:0] o_Checksum;

    int total = 0;
    int bad   = 0;

    int w_addr[1024];
    int w_din[1024];
    int w_t[1024];
    int n_wr;
    int done_t;
    int busy_bad;
    int en_bad;
    int x_bad;
    bit timed_out;

    threshold_loader dut (
        .clk         (clk),
        .rst         (rst),
        .i_Start     (i_Start),
        .i_ThrNum    (i_ThrNum),
        .i_ThrDen    (i_ThrDen),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_BRAM_Addr (o_BRAM_Addr),
        .o_BRAM_Din  (o_BRAM_Din),
        .o_BRAM_En   (o_BRAM_En),
        .o_BRAM_WrEn (o_BRAM_WrEn),
        .o_Checksum  (o_Checksum)
    );

    always #5 clk = ~clk;

    // Reference entry: floor(c*(N+D)/N), saturated; N == 0 gives all-ones.
    function automatic int model_entry(input int c, input int n, input int d);
        int q;
        if (n == 0) return SAT;
        q = (c * (n + d)) / n;
        return (q > SAT) ? SAT : q;
    endfunction

    function automatic int model_checksum(input int n, input int d);
        int s = 0;
        for (int c = 0; c < ENTRIES; c++) s += model_entry(c, n, d);
`ifdef THRESHOLD_LOADER_CHECKSUM_EN
        return s & 16'hFFFF;
`else
        return 0;
`endif
    endfunction

    // Pulses start, then records every write strobe with its cycle offset.
    // t = 0 is the first sample after the start edge.
    // Stops on o_Done, after stop_writes strobes (when non-zero), or at the cycle bound.
    task automatic collect(input int n, input int d, input int stop_writes, input int poke_t);
        n_wr = 0; done_t = -1; busy_bad = 0; en_bad = 0; x_bad = 0; timed_out = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            w_addr[i] = -1; w_din[i] = -1; w_t[i] = -1;
        end
        @(negedge clk);
        i_Start = 1'b1; i_ThrNum = 8'(n); i_ThrDen = 8'(d);
        @(negedge clk);
        i_Start = 1'b0;
        for (int t = 0; t < LOAD_LEN + 200; t++) begin
            if ($isunknown({o_Busy, o_Done, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn, o_Checksum}))
                x_bad++;
            if (o_BRAM_En !== o_BRAM_WrEn) en_bad++;
            if (o_BRAM_WrEn === 1'b1) begin
                if (n_wr < 1024) begin
                    w_addr[n_wr] = int'(o_BRAM_Addr);
                    w_din[n_wr]  = int'(o_BRAM_Din);
                    w_t[n_wr]    = t;
                end
                n_wr++;
            end
            if (o_Done === 1'b1) begin
                done_t = t; timed_out = 1'b0;
                if (o_Busy !== 1'b0) busy_bad++;
                break;
            end
            if (o_Busy !== 1'b1) busy_bad++;
            if (stop_writes > 0 && n_wr >= stop_writes) begin
                timed_out = 1'b0;
                break;
            end
            i_ThrNum = 8'($urandom);
            i_ThrDen = 8'($urandom);
            i_Start  = (t == poke_t);
            @(negedge clk);
        end
        i_Start = 1'b0;
    endtask

    task automatic applyStimulus_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset;
        applyStimulus_reset(3);
        total++; if (o_Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", o_Busy); end
        total++; if (o_Done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b exp=0", o_Done); end
        total++; if (o_BRAM_Addr !== 10'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0d exp=0", o_BRAM_Addr); end
        total++; if (o_BRAM_Din !== 11'd0) begin bad++; $display("[TB] FAIL reset_din got=%0d exp=0", o_BRAM_Din); end
        total++; if (o_BRAM_En !== 1'b0) begin bad++; $display("[TB] FAIL reset_en got=%0b exp=0", o_BRAM_En); end
        total++; if (o_BRAM_WrEn !== 1'b0) begin bad++; $display("[TB] FAIL reset_wren got=%0b exp=0", o_BRAM_WrEn); end
        total++; if (o_Checksum !== 16'd0) begin bad++; $display("[TB] FAIL reset_checksum got=%0d exp=0", o_Checksum); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full loads for several thresholds, with entries and timing checked against the model.
    task automatic test_full_loads;
        int ns[3] = '{1, 3, 0};
        int ds[3] = '{1, 1, 5};
        for (int k = 0; k < 3; k++) begin
            collect(ns[k], ds[k], 0, 5000 + 1000 * k);
            total++; if (timed_out) begin bad++; $display("[TB] FAIL load%0d_timeout got=no_done exp=done", k); end
            total++; if (n_wr != ENTRIES) begin bad++; $display("[TB] FAIL load%0d_writes got=%0d exp=%0d", k, n_wr, ENTRIES); end
            total++; if (done_t != LOAD_LEN) begin bad++; $display("[TB] FAIL load%0d_done_time got=%0d exp=%0d", k, done_t, LOAD_LEN); end
            total++; if (busy_bad != 0) begin bad++; $display("[TB] FAIL load%0d_busy got=%0d_bad_cycles exp=0", k, busy_bad); end
            total++; if (en_bad != 0) begin bad++; $display("[TB] FAIL load%0d_en_eq_wren got=%0d exp=0", k, en_bad); end
            total++; if (x_bad != 0) begin bad++; $display("[TB] FAIL load%0d_no_x got=%0d exp=0", k, x_bad); end
            for (int c = 0; c < ENTRIES; c++) begin
                total++;
                if (w_addr[c] != c || w_din[c] != model_entry(c, ns[k], ds[k]) || w_t[c] != 19 + PER_ENTRY * c) begin
                    bad++;
                    $display("[TB] FAIL load%0d_entry%0d got addr=%0d din=%0d t=%0d exp addr=%0d din=%0d t=%0d",
                             k, c, w_addr[c], w_din[c], w_t[c], c, model_entry(c, ns[k], ds[k]), 19 + PER_ENTRY * c);
                end
            end
            if (k == 0) begin
                total++; if (w_din[5] != 10) begin bad++; $display("[TB] FAIL n1d1_entry5 got=%0d exp=10", w_din[5]); end
                total++; if (w_din[920] != 1840) begin bad++; $display("[TB] FAIL n1d1_entry920 got=%0d exp=1840", w_din[920]); end
            end else if (k == 1) begin
                total++; if (w_din[0] != 0) begin bad++; $display("[TB] FAIL n3d1_entry0 got=%0d exp=0", w_din[0]); end
                total++; if (w_din[5] != 6) begin bad++; $display("[TB] FAIL n3d1_entry5 got=%0d exp=6", w_din[5]); end
                total++; if (w_din[920] != 1226) begin bad++; $display("[TB] FAIL n3d1_entry920 got=%0d exp=1226", w_din[920]); end
            end else begin
                total++; if (w_din[460] != SAT) begin bad++; $display("[TB] FAIL n0_entry460 got=%0d exp=%0d", w_din[460], SAT); end
            end
            @(negedge clk);
            total++;
            if (o_Checksum !== 16'(model_checksum(ns[k], ds[k]))) begin
                bad++;
                $display("[TB] FAIL load%0d_checksum got=%0d exp=%0d", k, o_Checksum, model_checksum(ns[k], ds[k]));
            end
            repeat (3) @(negedge clk);
        end
    endtask

    // Random threshold, stray start mid-load, reset right after entry 100,
    // then a fresh saturating load.
    task automatic test_abort_restart;
        int n = int'($urandom_range(1, 255));
        int d = int'($urandom_range(0, 255));
        int strobes = 0;
        int nonzero = 0;
        collect(n, d, 101, 500);
        total++; if (n_wr != 101) begin bad++; $display("[TB] FAIL abort_reached got=%0d exp=101", n_wr); end
        for (int c = 0; c <= 100; c++) begin
            total++;
            if (w_addr[c] != c || w_din[c] != model_entry(c, n, d) || w_t[c] != 19 + PER_ENTRY * c) begin
                bad++;
                $display("[TB] FAIL abort_entry%0d n=%0d d=%0d got addr=%0d din=%0d t=%0d exp addr=%0d din=%0d t=%0d",
                         c, n, d, w_addr[c], w_din[c], w_t[c], c, model_entry(c, n, d), 19 + PER_ENTRY * c);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({o_Busy, o_Done, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn, o_Checksum} !== '0) begin
            bad++;
            $display("[TB] FAIL abort_reset_outputs got busy=%0b done=%0b addr=%0d din=%0d en=%0b wren=%0b cks=%0d exp=all_zero",
                     o_Busy, o_Done, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_BRAM_WrEn, o_Checksum);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (o_BRAM_WrEn !== 1'b0) strobes++;
            if ({o_Busy, o_Done, o_BRAM_Addr, o_BRAM_Din, o_BRAM_En, o_Checksum} !== '0) nonzero++;
        end
        total++; if (strobes != 0) begin bad++; $display("[TB] FAIL abort_no_strobe got=%0d exp=0", strobes); end
        total++; if (nonzero != 0) begin bad++; $display("[TB] FAIL abort_idle_zero got=%0d exp=0", nonzero); end

        collect(1, 255, 0, 9000);
        total++; if (timed_out) begin bad++; $display("[TB] FAIL restart_timeout got=no_done exp=done"); end
        total++; if (n_wr != ENTRIES) begin bad++; $display("[TB] FAIL restart_writes got=%0d exp=%0d", n_wr, ENTRIES); end
        total++; if (done_t != LOAD_LEN) begin bad++; $display("[TB] FAIL restart_done_time got=%0d exp=%0d", done_t, LOAD_LEN); end
        total++; if (busy_bad != 0) begin bad++; $display("[TB] FAIL restart_busy got=%0d exp=0", busy_bad); end
        for (int c = 0; c < ENTRIES; c++) begin
            total++;
            if (w_addr[c] != c || w_din[c] != model_entry(c, 1, 255) || w_t[c] != 19 + PER_ENTRY * c) begin
                bad++;
                $display("[TB] FAIL restart_entry%0d got addr=%0d din=%0d t=%0d exp addr=%0d din=%0d t=%0d",
                         c, w_addr[c], w_din[c], w_t[c], c, model_entry(c, 1, 255), 19 + PER_ENTRY * c);
            end
        end
        total++; if (w_din[7] != 1792) begin bad++; $display("[TB] FAIL n1d255_entry7 got=%0d exp=1792", w_din[7]); end
        total++; if (w_din[8] != SAT) begin bad++; $display("[TB] FAIL n1d255_entry8 got=%0d exp=%0d", w_din[8], SAT); end
        @(negedge clk);
        total++;
        if (o_Checksum !== 16'(model_checksum(1, 255))) begin
            bad++;
            $display("[TB] FAIL restart_checksum got=%0d exp=%0d", o_Checksum, model_checksum(1, 255));
        end
    endtask

    initial begin
        $display("[TB] threshold_loader bench start");
        test_reset;
        test_full_loads;
        test_abort_restart;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
